instr_cache: RTL

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port (`read_m1`/`address1`/`data1`) and instruction memory. A hit returns the instruction in the same cycle. A miss stalls the fetch stage through `i_ready` while a full line is fetched over a request/valid handshake. Hit and access counters feed the performance report alongside `num_inst`.

---
 rtl/instr_cache_pkg.sv | 20 ++
 rtl/instr_cache_if.sv | 26 ++
 rtl/instr_cache_line_array.sv | 49 ++++
 rtl/instr_cache.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache: word width, controller states
// and the line-alignment helper.
package instr_cache_pkg;

   localparam int WORD_SIZE = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_e;

   // Clears the offset bits so the address names the first word of its line.
   function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] addr,
                                                       input int offset_bits);
      logic [WORD_SIZE-1:0] mask;
      mask = {WORD_SIZE{1'b1}} << offset_bits;
      return addr & mask;
   endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch port (datapath side) and line-fill port (memory side) of the
// instruction cache, bundled; the cache is the slave, the environment the master.
interface instr_cache_if #(
   parameter int LINE_WORDS = 4
) ();

   logic                                            i_read;
   logic [instr_cache_pkg::WORD_SIZE-1:0]            i_address;
   logic [instr_cache_pkg::WORD_SIZE-1:0]            i_data;
   logic                                            i_ready;
   logic                                            mem_read;
   logic [instr_cache_pkg::WORD_SIZE-1:0]            mem_address;
   logic [instr_cache_pkg::WORD_SIZE*LINE_WORDS-1:0] mem_data;
   logic                                            mem_valid;

   modport master (
      output i_read, i_address, mem_data, mem_valid,
      input  i_data, i_ready, mem_read, mem_address
   );

   modport slave (
      input  i_read, i_address, mem_data, mem_valid,
      output i_data, i_ready, mem_read, mem_address
   );

endinterface

// File: rtl/instr_cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read by
// index, whole-line synchronous write, synchronous clear of all valid bits.
module icache_line_array #(
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 4,
   parameter int INDEX_BITS = 2,
   parameter int TAG_BITS   = 12
) (
   input  logic                            clk,
   input  logic                            clr,
   input  logic                            wr_en,
   input  logic [INDEX_BITS-1:0]           wr_index,
   input  logic [TAG_BITS-1:0]             wr_tag,
   input  logic [WORD_SIZE*LINE_WORDS-1:0] wr_line,
   input  logic [INDEX_BITS-1:0]           rd_index,
   output logic                            rd_valid,
   output logic [TAG_BITS-1:0]             rd_tag,
   output logic [WORD_SIZE*LINE_WORDS-1:0] rd_line
);

   logic [NUM_LINES-1:0]            valid_r;
   logic [TAG_BITS-1:0]             tag_r  [NUM_LINES];
   logic [WORD_SIZE*LINE_WORDS-1:0] data_r [NUM_LINES];

   // Valid bits: cleared together; a clear in the same cycle as a fill wins.
   always_ff @(posedge clk) begin
      if (clr) begin
         valid_r <= '0;
      end else if (wr_en) begin
         valid_r[wr_index] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Tag and data words: only meaningful while the valid bit is set, so never cleared.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         tag_r[wr_index]  <= wr_tag;
         data_r[wr_index] <= wr_line;
      end
   end

   assign rd_valid = valid_r[rd_index];
   assign rd_tag   = tag_r[rd_index];
   assign rd_line  = data_r[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, a stalling
// line fill on a miss, and hit/access counters for the performance report.
module instr_cache
   import instr_cache_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 4
) (
   input  logic                clk,
   input  logic                reset,
   instr_cache_if.slave        bus,
   output logic [15:0]         hit_count,
   output logic [15:0]         access_count
);

   localparam int OFFSET_BITS = $clog2(LINE_WORDS);
   localparam int INDEX_BITS  = $clog2(NUM_LINES);
   localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
   localparam int LINE_BITS   = WORD_SIZE * LINE_WORDS;

   logic [OFFSET_BITS-1:0] offset_s;
   logic [INDEX_BITS-1:0]  index_s;
   logic [TAG_BITS-1:0]    tag_s;
   logic                   rd_valid_s;
   logic [TAG_BITS-1:0]    rd_tag_s;
   logic [LINE_BITS-1:0]   rd_line_s;
   logic                   hit_s;
   logic [WORD_SIZE-1:0]   word_s;

   icache_state_e          state_r;
   icache_state_e          state_next_s;
   logic                   start_fill_s;
   logic                   fill_done_s;
   logic                   fetch_done_s;
   logic                   i_ready_s;
   logic [WORD_SIZE-1:0]   i_data_s;
   logic                   wr_en_s;

   logic                   mem_read_r;
   logic [WORD_SIZE-1:0]   mem_address_r;
   logic [15:0]            hit_count_r;
   logic [15:0]            access_count_r;
   logic                   missed_r;

   assign offset_s = bus.i_address[OFFSET_BITS-1:0];
   assign index_s  = bus.i_address[OFFSET_BITS +: INDEX_BITS];
   assign tag_s    = bus.i_address[WORD_SIZE-1 -: TAG_BITS];

   // The fill writes the line named by the latched address, not the live one.
   assign wr_en_s = fill_done_s && !reset;

   icache_line_array #(
      .WORD_SIZE  (WORD_SIZE),
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_lines (
      .clk      (clk),
      .clr      (reset),
      .wr_en    (wr_en_s),
      .wr_index (mem_address_r[OFFSET_BITS +: INDEX_BITS]),
      .wr_tag   (mem_address_r[WORD_SIZE-1 -: TAG_BITS]),
      .wr_line  (bus.mem_data),
      .rd_index (index_s),
      .rd_valid (rd_valid_s),
      .rd_tag   (rd_tag_s),
      .rd_line  (rd_line_s)
   );

   assign hit_s = rd_valid_s && (rd_tag_s == tag_s);

   // Word select within the looked-up line.
   always_comb begin
      word_s = '0;
      for (int k = 0; k < LINE_WORDS; k++) begin
         if (offset_s == k[OFFSET_BITS-1:0]) begin
            word_s = rd_line_s[k*WORD_SIZE +: WORD_SIZE];
         end else begin
            word_s = word_s;
         end
      end
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state and fetch-port response; an idle port reads as ready with zero data.
   always_comb begin
      state_next_s = state_r;
      start_fill_s = 1'b0;
      fill_done_s  = 1'b0;
      i_ready_s    = 1'b0;
      i_data_s     = '0;
      case (state_r)
         IDLE: begin
            if (!bus.i_read) begin
               i_ready_s = 1'b1;
            end else if (hit_s) begin
               i_ready_s = 1'b1;
               i_data_s  = word_s;
            end else begin
               start_fill_s = 1'b1;
               state_next_s = FETCH;
            end
         end
         FETCH: begin
            if (bus.mem_valid) begin
               fill_done_s  = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = FETCH;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   assign fetch_done_s = bus.i_read && i_ready_s;

   // Fill request: raised with the aligned miss address, dropped when the line arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_read_r    <= 1'b0;
         mem_address_r <= '0;
      end else if (start_fill_s) begin
         mem_read_r    <= 1'b1;
         mem_address_r <= line_align(bus.i_address, OFFSET_BITS);
      end else if (fill_done_s) begin
         mem_read_r    <= 1'b0;
      end else begin
         mem_read_r    <= mem_read_r;
      end
   end

   // Counters; missed_r keeps a fetch that needed a fill from counting as a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count_r    <= 16'd0;
         access_count_r <= 16'd0;
         missed_r       <= 1'b0;
      end else if (fetch_done_s) begin
         access_count_r <= access_count_r + 16'd1;
         if (!missed_r) begin
            hit_count_r <= hit_count_r + 16'd1;
         end
         missed_r       <= 1'b0;
      end else if (start_fill_s) begin
         missed_r       <= 1'b1;
      end
   end

   assign bus.i_ready     = i_ready_s;
   assign bus.i_data      = i_data_s;
   assign bus.mem_read    = mem_read_r;
   assign bus.mem_address = mem_address_r;
   assign hit_count       = hit_count_r;
   assign access_count    = access_count_r;

endmodule
